// File: rtl/bbox_draw.sv
// bbox_draw: draws the outline of a clamped axis-aligned box into pixel memory,
// one pixel per cycle, with an en/rdy start handshake and a done pulse.
module bbox_draw #(
  parameter int         WIDTH  = 100,
  parameter int         HEIGHT = 100,
  parameter int         ADDR_W = 14,
  parameter logic [7:0] COLOUR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [10:0]       xMin,
  input  logic [10:0]       xMax,
  input  logic [10:0]       yMin,
  input  logic [10:0]       yMax,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wrdata,
  output logic              wren,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE} state_t;
  localparam logic [10:0]       X_LIM = 11'(WIDTH - 1);
  localparam logic [10:0]       Y_LIM = 11'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(WIDTH);
  state_t            r_state;
  logic [10:0]       r_x0, r_x1, r_y0, r_y1, r_x, r_y;
  logic [ADDR_W-1:0] r_top, r_bot;
  logic [10:0]       w_x0, w_x1, w_y0, w_y1;
  logic [ADDR_W-1:0] w_top, w_bot;
  logic              w_ok;

  // y*WIDTH as a shift-and-add over the bits of y, so no multiplier is built
  function automatic logic [ADDR_W-1:0] row_base(input logic [10:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 11; i++) acc = acc + (y[i] ? STEP << i : '0);
    return acc;
  endfunction

  always_comb begin
    w_x0  = xMin > X_LIM ? X_LIM : xMin;
    w_x1  = xMax > X_LIM ? X_LIM : xMax;
    w_y0  = yMin > Y_LIM ? Y_LIM : yMin;
    w_y1  = yMax > Y_LIM ? Y_LIM : yMax;
    w_ok  = (w_x0 <= w_x1) && (w_y0 <= w_y1);
    w_top = row_base(w_y0);
    w_bot = row_base(w_y1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      rdy     <= 1'b1;
      addr    <= '0;
      wrdata  <= '0;
      wren    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_top   <= '0;
      r_bot   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (en) begin
          rdy   <= 1'b0;
          err   <= !w_ok;
          r_x0  <= w_x0;
          r_x1  <= w_x1;
          r_y0  <= w_y0;
          r_y1  <= w_y1;
          r_x   <= w_x0;
          r_top <= w_top;
          r_bot <= w_bot;
          if (w_ok) begin
            r_state <= TOP;
            wren    <= 1'b1;
            wrdata  <= COLOUR;
            addr    <= w_top + ADDR_W'(w_x0);
          end else begin
            r_state <= DONE;
            done    <= 1'b1;
          end
        end
        TOP, BOTTOM: begin
          if (r_x < r_x1) begin
            r_x  <= r_x + 11'd1;
            addr <= addr + 1'b1;
          end else if (r_state == TOP && r_y1 != r_y0) begin
            r_state <= BOTTOM;
            r_x     <= r_x0;
            addr    <= r_bot + ADDR_W'(r_x0);
          end else if (r_y1 - r_y0 >= 11'd2) begin
            r_state <= LEFT;
            r_y     <= r_y0 + 11'd1;
            addr    <= r_top + STEP + ADDR_W'(r_x0);
          end else begin
            r_state <= DONE;
            wren    <= 1'b0;
            done    <= 1'b1;
          end
        end
        LEFT, RIGHT: begin
          // columns stop one row short of yMax: the corners belong to the rows
          if (r_y + 11'd1 < r_y1) begin
            r_y  <= r_y + 11'd1;
            addr <= addr + STEP;
          end else if (r_state == LEFT && r_x1 != r_x0) begin
            r_state <= RIGHT;
            r_y     <= r_y0 + 11'd1;
            addr    <= r_top + STEP + ADDR_W'(r_x1);
          end else begin
            r_state <= DONE;
            wren    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          rdy     <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bbox_draw.sv
// tb_bbox_draw: scoreboard bench for bbox_draw; expected pixel stream comes from
// enumerating the box outline with plain arithmetic.
module tb_bbox_draw;
  localparam int WIDTH = 100;
  localparam int HEIGHT = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] xMin = '0, xMax = '0, yMin = '0, yMax = '0;
  logic        rdy, wren, done, err;
  logic [13:0] addr;
  logic [7:0]  wrdata;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  bit err_q[$];

  bbox_draw #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(14), .COLOUR(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .rdy(rdy), .addr(addr), .wrdata(wrdata), .wren(wren), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outline pixels in drawing order: top row, bottom row, left column, right column
  task automatic expect_box(input int a, input int b, input int c, input int d,
                            output int nw, output bit bad);
    int x0, y0, x1, y1;
    x0 = (a & 2047) > WIDTH - 1 ? WIDTH - 1 : (a & 2047);
    y0 = (b & 2047) > HEIGHT - 1 ? HEIGHT - 1 : (b & 2047);
    x1 = (c & 2047) > WIDTH - 1 ? WIDTH - 1 : (c & 2047);
    y1 = (d & 2047) > HEIGHT - 1 ? HEIGHT - 1 : (d & 2047);
    bad = (x0 > x1) || (y0 > y1);
    nw = 0;
    if (!bad) begin
      for (int x = x0; x <= x1; x++) begin exp_q.push_back(y0 * WIDTH + x); nw++; end
      if (y1 != y0)
        for (int x = x0; x <= x1; x++) begin exp_q.push_back(y1 * WIDTH + x); nw++; end
      for (int y = y0 + 1; y < y1; y++) begin exp_q.push_back(y * WIDTH + x0); nw++; end
      if (x1 != x0)
        for (int y = y0 + 1; y < y1; y++) begin exp_q.push_back(y * WIDTH + x1); nw++; end
    end
    err_q.push_back(bad);
  endtask

  task automatic drive(input int a, input int b, input int c, input int d);
    xMin = 11'(a);
    yMin = 11'(b);
    xMax = 11'(c);
    yMax = 11'(d);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  // Called at a negedge with rdy=1; returns at the negedge where rdy is back.
  task automatic go(input int a, input int b, input int c, input int d);
    int nw, k;
    bit bad;
    expect_box(a, b, c, d, nw, bad);
    drive(a, b, c, d);
    k = 0;
    do begin @(negedge clk); k++; end while (!rdy && k < 20000);
    chk("latency", k, nw + 2);
    chk("err_hold", int'(err), int'(bad));
    chk("drained", exp_q.size(), 0);
    exp_q.delete();
    err_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wren) begin
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("addr", int'(addr), exp_q.pop_front());
        chk("wrdata", int'(wrdata), 255);
      end
      if (done) begin
        chk("done_pending_writes", exp_q.size(), 0);
        chk("done_wren", int'(wren), 0);
        chk("done_rdy", int'(rdy), 0);
        chk("done_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) chk("err", int'(err), int'(err_q.pop_front()));
      end
    end
  end

  initial begin
    int nw, k, cnt;
    bit bad;
    #12;
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_addr", int'(addr), 0);
    chk("rst_wrdata", int'(wrdata), 0);
    chk("rst_wren", int'(wren), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(10, 20, 12, 22);
    go(5, 5, 5, 5);
    go(0, 0, 99, 0);
    go(7, 0, 7, 3);
    go(30, 5, 20, 9);
    go(1, 1, 2, 2);
    go(95, 98, 150, 200);
    go(0, 0, 99, 99);
    for (int i = 0; i < 30; i++) begin
      int a, b;
      a = int'($urandom_range(0, 110));
      b = int'($urandom_range(0, 110));
      go(a, b, a + int'($urandom_range(0, 20)) - 2, b + int'($urandom_range(0, 20)) - 2);
    end
    expect_box(40, 40, 43, 43, nw, bad);
    drive(40, 40, 43, 43);
    k = 0;
    cnt = 0;
    while (cnt < 3 && k < 100) begin
      @(negedge clk);
      k++;
      if (wren) cnt++;
    end
    chk("third_write_seen", cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wren", int'(wren), 0);
    chk("midrst_rdy", int'(rdy), 1);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    exp_q.delete();
    err_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    go(40, 40, 43, 43);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
